iomemory_arbiter: RTL and testbench

Arbitrates the single data port of the I/O memory between three requesters: the scalar load/store unit, the vector load/store unit and the image loader, which streams input pixels into the image region. Holds one transaction at a time and sequences the memory's write enable, address and data buses. Drives read-data capture after a fixed read latency and returns a one-cycle completion pulse to the granted requester. Sits between the processor's memory stage and the iomemory instance; the GPU port of the memory is not touched.

---
 rtl/iomemory_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_iomemory_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/iomemory_arbiter.sv
// iomemory_arbiter
// Shares the single data port of the I/O memory between the scalar LSU,
// the vector LSU and the image loader. Handles one transaction at a time:
// a round-robin grant in IDLE, one ACCESS cycle on the memory buses,
// READ_LATENCY WAIT cycles for reads, then a one-cycle DONE pulse to the
// granted requester.
//
// State   | meaning
// IDLE    | no transaction; arbitrate among pending requests
// ACCESS  | address/data/write-enable presented to the memory
// WAIT    | read latency countdown; data captured on the last cycle
// DONE    | done (and err if misaligned) pulsed to the winner
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   s_* / v_* / l_*               scalar / vector / loader request side
//   err                           rejected transaction, valid with done
//   mem_*                         iomemory data port
//   busy                          high whenever the FSM is not in IDLE
module iomemory_arbiter #(
    parameter int READ_LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_req,
    input  logic         s_we,
    input  logic [31:0]  s_address,
    input  logic [31:0]  s_wdata,
    output logic         s_done,
    output logic [31:0]  s_rdata,
    input  logic         v_req,
    input  logic         v_we,
    input  logic [31:0]  v_address,
    input  logic [63:0]  v_wdata,
    output logic         v_done,
    output logic [127:0] v_rdata,
    input  logic         l_req,
    input  logic [31:0]  l_address,
    input  logic [31:0]  l_wdata,
    output logic         l_done,
    output logic         err,
    output logic         mem_write_enable,
    output logic [31:0]  mem_address,
    output logic [31:0]  mem_data_input,
    output logic [63:0]  mem_vector_input,
    input  logic [31:0]  mem_data_output,
    input  logic [127:0] mem_vector_output,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    localparam logic [1:0] GR_S = 2'd0;
    localparam logic [1:0] GR_V = 2'd1;
    localparam logic [1:0] GR_L = 2'd2;
    localparam logic [1:0] WAIT_INIT = 2'(READ_LATENCY - 1);

    state_t       state_q, state_d;
    logic [1:0]   last_grant_q, grant_q;
    logic         we_q, err_q;
    logic [1:0]   cnt_q;
    logic [31:0]  addr_q, din_q;
    logic [63:0]  vin_q;
    logic [31:0]  s_rdata_q;
    logic [127:0] v_rdata_q;

    logic         any_req;
    logic [1:0]   win;
    logic         win_we;
    logic [31:0]  win_addr;
    logic         win_misaligned;

    assign any_req = s_req | v_req | l_req;

    // Round-robin: search starts with the requester after last_grant.
    always_comb begin
        win = GR_S;
        unique case (last_grant_q)
            GR_S: begin
                if (v_req)      win = GR_V;
                else if (l_req) win = GR_L;
                else            win = GR_S;
            end
            GR_V: begin
                if (l_req)      win = GR_L;
                else if (s_req) win = GR_S;
                else            win = GR_V;
            end
            default: begin
                if (s_req)      win = GR_S;
                else if (v_req) win = GR_V;
                else            win = GR_L;
            end
        endcase
    end

    always_comb begin
        win_we   = 1'b1;
        win_addr = l_address;
        unique case (win)
            GR_S: begin
                win_we   = s_we;
                win_addr = s_address;
            end
            GR_V: begin
                win_we   = v_we;
                win_addr = v_address;
            end
            default: begin
                win_we   = 1'b1;
                win_addr = l_address;
            end
        endcase
    end

    assign win_misaligned = (win_addr[1:0] != 2'b00);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (any_req) state_d = win_misaligned ? DONE : ACCESS;
            ACCESS: state_d = we_q ? DONE : WAIT;
            WAIT:   if (cnt_q == 2'd0) state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= GR_L;
            grant_q      <= GR_S;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= 2'd0;
            addr_q       <= '0;
            din_q        <= '0;
            vin_q        <= '0;
            s_rdata_q    <= '0;
            v_rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        grant_q      <= win;
                        last_grant_q <= win;
                        we_q         <= win_we;
                        err_q        <= win_misaligned;
                        // Rejected transactions leave the memory buses untouched.
                        if (!win_misaligned) begin
                            addr_q <= win_addr;
                            din_q  <= (win == GR_S) ? s_wdata :
                                      (win == GR_L) ? l_wdata : 32'd0;
                            vin_q  <= (win == GR_V) ? v_wdata : 64'd0;
                        end
                    end
                end
                ACCESS: cnt_q <= WAIT_INIT;
                WAIT: begin
                    if (cnt_q == 2'd0) begin
                        if (grant_q == GR_S) s_rdata_q <= mem_data_output;
                        if (grant_q == GR_V) v_rdata_q <= mem_vector_output;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_write_enable = (state_q == ACCESS) && we_q;
    assign mem_address      = addr_q;
    assign mem_data_input   = din_q;
    assign mem_vector_input = vin_q;

    assign s_done  = (state_q == DONE) && (grant_q == GR_S);
    assign v_done  = (state_q == DONE) && (grant_q == GR_V);
    assign l_done  = (state_q == DONE) && (grant_q == GR_L);
    assign err     = (state_q == DONE) && err_q;
    assign busy    = (state_q != IDLE);
    assign s_rdata = s_rdata_q;
    assign v_rdata = v_rdata_q;

endmodule

// File: tb/tb_iomemory_arbiter.sv
module tb_iomemory_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         s_req, s_we, v_req, v_we, l_req;
    logic [31:0]  s_address, s_wdata, v_address, l_address, l_wdata;
    logic [63:0]  v_wdata;
    logic [31:0]  mem_data_output;
    logic [127:0] mem_vector_output;

    logic         s_done, v_done, l_done, err, mem_write_enable, busy;
    logic [31:0]  s_rdata, mem_address, mem_data_input;
    logic [127:0] v_rdata;
    logic [63:0]  mem_vector_input;

    // Second instance with READ_LATENCY=3, driven only through s_req2.
    logic         s_req2, v_req2, l_req2;
    logic         s_done2, v_done2, l_done2, err2, mem_we2, busy2;
    logic [31:0]  s_rdata2, mem_addr2, mem_din2;
    logic [127:0] v_rdata2;
    logic [63:0]  mem_vin2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    iomemory_arbiter #(.READ_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_req(s_req), .s_we(s_we), .s_address(s_address), .s_wdata(s_wdata),
        .s_done(s_done), .s_rdata(s_rdata),
        .v_req(v_req), .v_we(v_we), .v_address(v_address), .v_wdata(v_wdata),
        .v_done(v_done), .v_rdata(v_rdata),
        .l_req(l_req), .l_address(l_address), .l_wdata(l_wdata), .l_done(l_done),
        .err(err), .mem_write_enable(mem_write_enable), .mem_address(mem_address),
        .mem_data_input(mem_data_input), .mem_vector_input(mem_vector_input),
        .mem_data_output(mem_data_output), .mem_vector_output(mem_vector_output),
        .busy(busy)
    );

    iomemory_arbiter #(.READ_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .s_req(s_req2), .s_we(s_we), .s_address(s_address), .s_wdata(s_wdata),
        .s_done(s_done2), .s_rdata(s_rdata2),
        .v_req(v_req2), .v_we(v_we), .v_address(v_address), .v_wdata(v_wdata),
        .v_done(v_done2), .v_rdata(v_rdata2),
        .l_req(l_req2), .l_address(l_address), .l_wdata(l_wdata), .l_done(l_done2),
        .err(err2), .mem_write_enable(mem_we2), .mem_address(mem_addr2),
        .mem_data_input(mem_din2), .mem_vector_input(mem_vin2),
        .mem_data_output(mem_data_output), .mem_vector_output(mem_vector_output),
        .busy(busy2)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int           who;     // 0 scalar, 1 vector, 2 loader
        logic         we;
        logic [31:0]  addr;
        logic [63:0]  wdata;
        logic [127:0] rd;      // value the memory presents on its outputs
        int           cyc;     // samples after the request edge until done
        int           wecnt;
        logic         err;
        logic [31:0]  din;
        logic [63:0]  vin;
        logic [127:0] rdata;   // expected s_rdata / v_rdata at done
    } vec_t;

    vec_t vecs[8];

    task automatic apply(input vec_t v);
        int   cyc;
        int   wecnt;
        bit   got;
        logic [2:0] d;
        @(negedge clk);
        mem_data_output   = v.rd[31:0];
        mem_vector_output = v.rd;
        case (v.who)
            0: begin s_req = 1; s_we = v.we; s_address = v.addr; s_wdata = v.wdata[31:0]; end
            1: begin v_req = 1; v_we = v.we; v_address = v.addr; v_wdata = v.wdata; end
            default: begin l_req = 1; l_address = v.addr; l_wdata = v.wdata[31:0]; end
        endcase
        cyc = 0; wecnt = 0; got = 0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            d = {s_done, v_done, l_done};
            if (mem_write_enable) begin
                wecnt++;
                chk("we_addr", mem_address, v.addr);
                chk("we_din", mem_data_input, v.din);
                chk("we_vin", mem_vector_input, v.vin);
            end
            if (d != 3'b000) begin
                got = 1;
                chk("done_who", d, 3'b100 >> v.who);
                chk("done_err", err, v.err);
                if (v.who == 0 && !v.we) chk("s_rdata", s_rdata, v.rdata);
                if (v.who == 1 && !v.we) chk("v_rdata", v_rdata, v.rdata);
            end else begin
                chk("err_outside_done", err, 1'b0);
                chk("busy_in_txn", busy, 1'b1);
                if (v.addr[1:0] == 2'b00) chk("addr_hold", mem_address, v.addr);
            end
        end
        chk("done_cycle", cyc, v.cyc);
        chk("we_cycles", wecnt, v.wecnt);
        s_req = 0; v_req = 0; l_req = 0;
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);
        chk("idle_done", {s_done, v_done, l_done}, 3'b000);
    endtask

    initial begin
        logic [2:0] d;
        logic [2:0] order[4];
        int         ng;
        int         cyc;
        bit         got;

        vecs[0] = '{0, 1'b1, 32'h100,   64'hA, 128'h0, 2, 1, 1'b0, 32'hA, 64'h0, 128'h0};
        vecs[1] = '{0, 1'b0, 32'h100,   64'h0, 128'hA, 3, 0, 1'b0, 32'h0, 64'h0, 128'hA};
        vecs[2] = '{1, 1'b1, 32'h404,   64'h1234567890ABCDEF, 128'h0, 2, 1, 1'b0,
                    32'h0, 64'h1234567890ABCDEF, 128'h0};
        vecs[3] = '{1, 1'b0, 32'h404,   64'h0, 128'hFEDCBA98765432101234567890ABCDEF, 3, 0, 1'b0,
                    32'h0, 64'h0, 128'hFEDCBA98765432101234567890ABCDEF};
        vecs[4] = '{2, 1'b1, 32'h30002, 64'h99, 128'h0, 1, 0, 1'b1, 32'h0, 64'h0, 128'h0};
        vecs[5] = '{2, 1'b1, 32'h30004, 64'h55, 128'h0, 2, 1, 1'b0, 32'h55, 64'h0, 128'h0};
        vecs[6] = '{0, 1'b0, 32'h101,   64'h0, 128'hDEAD, 1, 0, 1'b1, 32'h0, 64'h0, 128'hA};
        vecs[7] = '{1, 1'b0, 32'h500,   64'h0, 128'h11112222333344445555666677778888, 3, 0, 1'b0,
                    32'h0, 64'h0, 128'h11112222333344445555666677778888};

        rst_n = 0;
        s_req = 0; s_we = 0; s_address = 0; s_wdata = 0;
        v_req = 0; v_we = 0; v_address = 0; v_wdata = 0;
        l_req = 0; l_address = 0; l_wdata = 0;
        s_req2 = 0; v_req2 = 0; l_req2 = 0;
        mem_data_output = 0; mem_vector_output = 0;

        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_dones", {s_done, v_done, l_done, err}, 4'b0);
        chk("rst_mem_we", mem_write_enable, 1'b0);
        chk("rst_mem_bus", {mem_address, mem_data_input, mem_vector_input}, 128'h0);
        chk("rst_rdata", {s_rdata, v_rdata}, 160'h0);

        @(negedge clk);
        rst_n = 1;

        foreach (vecs[i]) apply(vecs[i]);

        // Reset during the WAIT cycle of a vector read aborts it.
        @(negedge clk);
        v_req = 1; v_we = 0; v_address = 32'h404;
        mem_vector_output = 128'hCAFE;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("wait_busy", busy, 1'b1);
        rst_n = 0;
        #1;
        chk("abort_we", mem_write_enable, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_vdone", v_done, 1'b0);
        chk("abort_vrdata", v_rdata, 128'h0);
        v_req = 0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", {s_done, v_done, l_done}, 3'b000);
        end

        // All three requesters held high from reset.
        s_req = 1; s_we = 1; s_address = 32'h10; s_wdata = 32'h1;
        v_req = 1; v_we = 1; v_address = 32'h20; v_wdata = 64'h2;
        l_req = 1; l_address = 32'h30; l_wdata = 32'h3;
        @(negedge clk);
        rst_n = 1;
        ng = 0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            d = {s_done, v_done, l_done};
            chk("rr_busy", busy, (k % 3) != 0);
            if (d != 3'b000) begin
                chk("rr_onehot", $countones(d), 1);
                chk("rr_done_slot", k % 3, 2);
                if (ng < 4) order[ng] = d;
                ng++;
            end
        end
        chk("rr_grants", ng, 4);
        chk("rr_order", {order[0], order[1], order[2], order[3]}, {3'b100, 3'b010, 3'b001, 3'b100});
        s_req = 0; v_req = 0; l_req = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rr_idle", busy, 1'b0);

        // READ_LATENCY=3 scalar read on the second instance.
        s_we = 0; s_address = 32'h200; mem_data_output = 32'hBAD;
        s_req2 = 1;
        cyc = 0; got = 0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (s_done2) begin
                got = 1;
                chk("l3_rdata", s_rdata2, 32'h77);
                chk("l3_err", err2, 1'b0);
            end else begin
                chk("l3_addr", mem_addr2, 32'h200);
                chk("l3_we", mem_we2, 1'b0);
                mem_data_output = (cyc == 4) ? 32'h77 : 32'hBAD;
            end
        end
        chk("l3_done_cycle", cyc, 5);
        s_req2 = 0;
        @(negedge clk);
        chk("l3_idle", busy2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
